// File: rtl/mc_pkg.sv
// Shared definitions for the MC-stage MV buffer read arbiter: widths, requester ids, return tag.
// The MV word width follows `FMV_WIDTH (defaults to 16 when the including build does not set it).
`ifndef FMV_WIDTH
`define FMV_WIDTH 16
`endif

package mc_pkg;
   localparam int MV_ADDR_W = 6;
   localparam int MV_W_DEF  = 2*`FMV_WIDTH;
   localparam int WAIT_W    = 3;

   localparam logic REQ_MC  = 1'b0;
   localparam logic REQ_MVD = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } mv_tag_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/mc_mv_arb_if.sv
// Request/grant/return bundle between the two MV readers, the arbiter and the MV buffer port.
// Signal names keep the arbiter's point of view; the slave modport is the arbiter itself.
interface mc_mv_arb_if #(
   parameter int MV_W   = mc_pkg::MV_W_DEF,
   parameter int ADDR_W = mc_pkg::MV_ADDR_W
);
   logic              mc_req_i;
   logic [ADDR_W-1:0] mc_addr_i;
   logic              mc_gnt_o;
   logic              mc_rvalid_o;
   logic [MV_W-1:0]   mc_rdata_o;
   logic              mvd_req_i;
   logic [ADDR_W-1:0] mvd_addr_i;
   logic              mvd_gnt_o;
   logic              mvd_rvalid_o;
   logic [MV_W-1:0]   mvd_rdata_o;
   logic              mv_rden_o;
   logic [ADDR_W-1:0] mv_rdaddr_o;
   logic [MV_W-1:0]   mv_data_i;

   modport master (
      output mc_req_i, mc_addr_i, mvd_req_i, mvd_addr_i, mv_data_i,
      input  mc_gnt_o, mc_rvalid_o, mc_rdata_o, mvd_gnt_o, mvd_rvalid_o, mvd_rdata_o,
      input  mv_rden_o, mv_rdaddr_o
   );

   modport slave (
      input  mc_req_i, mc_addr_i, mvd_req_i, mvd_addr_i, mv_data_i,
      output mc_gnt_o, mc_rvalid_o, mc_rdata_o, mvd_gnt_o, mvd_rvalid_o, mvd_rdata_o,
      output mv_rden_o, mv_rdaddr_o
   );
endinterface

// File: rtl/mc_mv_tag_pipe.sv
// RD_LAT-deep shift register of {valid, owner} tags that tracks which requester owns
// the word coming back from the MV buffer.
module mc_mv_tag_pipe
   import mc_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic    clk,
   input  logic    rstn,
   input  mv_tag_t tag_i,
   output mv_tag_t tag_o
);
   mv_tag_t pipe_q [RD_LAT];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= tag_i;
         for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tag_o = pipe_q[RD_LAT-1];
endmodule

// File: rtl/mc_mv_arb.sv
// Cycle-level arbiter for the MV buffer read port shared by chroma MC and MVD.
// Define MC_MV_ARB_RR_EN for round-robin conflict resolution instead of fixed MC priority.
module mc_mv_arb
   import mc_pkg::*;
#(
   parameter int MV_W     = MV_W_DEF,
   parameter int ADDR_W   = MV_ADDR_W,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        start_i,
   mc_mv_arb_if.slave  bus,
   output logic [15:0] conflict_cnt_o
);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] mc_wait_q, mc_wait_d, mc_wait_eff;
   logic [WAIT_W-1:0] mvd_wait_q, mvd_wait_d, mvd_wait_eff;
   logic [15:0]       cnt_q, cnt_d;
   logic              both_req, mc_win, mvd_win, rden;
   logic [ADDR_W-1:0] rdaddr;
   logic [MV_W-1:0]   rdata;
   mv_tag_t           tag_in, tag_out;
`ifdef MC_MV_ARB_RR_EN
   logic              rr_q, rr_d, rr_eff;
`endif

   // start_i acts on the same cycle: arbitration sees already-cleared state.
   always_comb begin
      mc_wait_eff  = start_i ? '0 : mc_wait_q;
      mvd_wait_eff = start_i ? '0 : mvd_wait_q;
`ifdef MC_MV_ARB_RR_EN
      rr_eff = start_i ? REQ_MC : rr_q;
`endif
      both_req = bus.mc_req_i & bus.mvd_req_i;
      mc_win   = 1'b0;
      mvd_win  = 1'b0;
      if (rstn) begin
         if (bus.mvd_req_i && (mvd_wait_eff == WAIT_MAX))     mvd_win = 1'b1;
         else if (bus.mc_req_i && (mc_wait_eff == WAIT_MAX))  mc_win  = 1'b1;
         else if (both_req) begin
`ifdef MC_MV_ARB_RR_EN
            if (rr_eff == REQ_MVD) mvd_win = 1'b1;
            else                   mc_win  = 1'b1;
`else
            mc_win = 1'b1;
`endif
         end
         else if (bus.mc_req_i)  mc_win  = 1'b1;
         else if (bus.mvd_req_i) mvd_win = 1'b1;
      end
   end

   always_comb begin
      mc_wait_d  = '0;
      mvd_wait_d = '0;
      if (bus.mc_req_i && !mc_win)
         mc_wait_d = (mc_wait_eff >= WAIT_MAX) ? WAIT_MAX : mc_wait_eff + 3'd1;
      if (bus.mvd_req_i && !mvd_win)
         mvd_wait_d = (mvd_wait_eff >= WAIT_MAX) ? WAIT_MAX : mvd_wait_eff + 3'd1;
      cnt_d = start_i ? 16'd0 : cnt_q;
      if (both_req) cnt_d = sat_inc16(cnt_d);
`ifdef MC_MV_ARB_RR_EN
      rr_d = rr_eff;
      if (both_req && mc_win)  rr_d = REQ_MVD;
      if (both_req && mvd_win) rr_d = REQ_MC;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mc_wait_q  <= '0;
         mvd_wait_q <= '0;
         cnt_q      <= '0;
`ifdef MC_MV_ARB_RR_EN
         rr_q       <= REQ_MC;
`endif
      end else begin
         mc_wait_q  <= mc_wait_d;
         mvd_wait_q <= mvd_wait_d;
         cnt_q      <= cnt_d;
`ifdef MC_MV_ARB_RR_EN
         rr_q       <= rr_d;
`endif
      end
   end

   assign rden   = mc_win | mvd_win;
   assign rdaddr = mc_win ? bus.mc_addr_i : (mvd_win ? bus.mvd_addr_i : '0);

   always_comb begin
      tag_in       = '0;
      tag_in.valid = rden;
      tag_in.owner = mvd_win ? REQ_MVD : REQ_MC;
   end

   mc_mv_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk   (clk),
      .rstn  (rstn),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   assign rdata = bus.mv_data_i;

   assign bus.mc_gnt_o     = mc_win;
   assign bus.mvd_gnt_o    = mvd_win;
   assign bus.mv_rden_o    = rden;
   assign bus.mv_rdaddr_o  = rdaddr;
   assign bus.mc_rvalid_o  = tag_out.valid & (tag_out.owner == REQ_MC);
   assign bus.mvd_rvalid_o = tag_out.valid & (tag_out.owner == REQ_MVD);
   assign bus.mc_rdata_o   = bus.mc_rvalid_o  ? rdata : '0;
   assign bus.mvd_rdata_o  = bus.mvd_rvalid_o ? rdata : '0;
   assign conflict_cnt_o   = cnt_q;
endmodule

// File: doc/mc_mv_arb.md
# mc_mv_arb

Arbiter for the single read port of the FME MV buffer, shared by the chroma motion-compensation engine and the MVD engine inside the MC stage. It replaces the static access-select mux with cycle-level arbitration, so both engines can fetch 8x8 PU MVs in the same LCU window. It routes returned MV data back to the requester that issued each read, prevents starvation, and counts contention cycles for profiling.

## Interface
Parameters:
- MV_W, default 2*`FMV_WIDTH: width of one MV buffer word.
- ADDR_W, default 6: MV buffer address width (64 entries).
- RD_LAT, default 1: MV buffer read latency in cycles, range 1..3.
- MAX_WAIT, default 4: consecutive lost cycles after which a requester is forced to win.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active low
- start_i  in  1  LCU start pulse; clears arbitration state and the statistic
- mc_req_i  in  1  chroma MC read request, active high
- mc_addr_i  in  ADDR_W  chroma MC read address
- mc_gnt_o  out  1  chroma MC grant
- mc_rvalid_o  out  1  chroma MC read data valid
- mc_rdata_o  out  MV_W  chroma MC read data
- mvd_req_i  in  1  MVD read request, active high (polarity is normalised at the instantiating wrapper)
- mvd_addr_i  in  ADDR_W  MVD read address
- mvd_gnt_o  out  1  MVD grant
- mvd_rvalid_o  out  1  MVD read data valid
- mvd_rdata_o  out  MV_W  MVD read data
- mv_rden_o  out  1  MV buffer read enable, active high
- mv_rdaddr_o  out  ADDR_W  MV buffer read address
- mv_data_i  in  MV_W  MV buffer read data
- conflict_cnt_o  out  16  count of cycles in which both requests were asserted; saturating

## Operation
- Request/grant: a requester holds req and addr stable until it sees gnt in the same cycle. A granted cycle is one completed read. Requesters issue back-to-back reads by keeping req high.
- At most one grant per cycle. mv_rden_o = mc_gnt_o | mvd_gnt_o. mv_rdaddr_o takes the winner's address, or 0 when idle.
- Arbitration order, evaluated in sequence:
  - Starvation override: a requester whose wait counter equals MAX_WAIT wins.
  - If only one requester is asserting req, it wins.
  - If both are asserting req, the default policy is fixed priority with MC winning.
- Wait counters (one per requester, 3 bits):
  - Increment when the requester asserts req and loses.
  - Clear when it is granted or stops requesting.
  - Saturate at MAX_WAIT.
  - If both counters reach MAX_WAIT together, MVD wins.
- Return path:
  - A tag pipeline RD_LAT deep carries {valid, owner}.
  - On tag exit, the owner's rvalid is asserted. Its rdata = mv_data_i; the non-owner's rdata is 0.
- conflict_cnt_o increments on each cycle where mc_req_i & mvd_req_i, saturates at 16'hFFFF, and clears on start_i.
- start_i:
  - Synchronously clears the wait counters, conflict_cnt_o and the RR pointer.
  - Does not flush the tag pipeline; reads already in flight still return rvalid.
  - A request in the same cycle as start_i is arbitrated with the cleared state.

## Timing
- Grant is combinational from req and registered state, so it has zero-cycle latency and the read issues in the request cycle.
- rvalid/rdata appear exactly RD_LAT cycles after the grant cycle. Back-to-back grants give back-to-back rvalid with no bubble.
- Reset values: all gnt, rvalid and rden outputs are 0; rdata, rdaddr and conflict_cnt_o are 0; wait counters are 0; RR pointer = MC; tag pipeline is invalid.
- Reset asserted mid-read drops in-flight tags; no rvalid is produced after reset release.

## Configuration
- MC_MV_ARB_RR_EN defined:
  - On a conflict without a starvation override, a 1-bit round-robin pointer selects the winner. The pointer starts at MC.
  - The pointer moves to the other requester after each conflict win.
- Not defined: fixed MC priority as described above, and the pointer register is absent.
- The starvation override is active in both builds.

## Structure
- Shared package mc_pkg holds:
  - MV_ADDR_W = 6.
  - The MV word width derived from `FMV_WIDTH.
  - The requester id constants: REQ_MC = 1'b0, REQ_MVD = 1'b1.
- One sub-module, mc_mv_tag_pipe: a parameterised RD_LAT-deep shift register of {valid, owner} with asynchronous active-low reset.

## Test plan
- MC only, addr 5, 6, 7 on consecutive cycles -> mv_rden_o high for 3 cycles with rdaddr 5, 6, 7; mc_rvalid_o high on the following 3 cycles (RD_LAT=1); mvd_rvalid_o stays 0.
- Both requesting for 10 cycles, fixed priority, MAX_WAIT=4 -> MVD granted on cycles 5 and 10; conflict_cnt_o = 10.
- Same stimulus with MC_MV_ARB_RR_EN -> grants alternate MC, MVD, MC, ...; each requester gets 5 grants.
- RD_LAT=3, grants MC then MVD then MC in consecutive cycles -> rvalid arrives 3 cycles later in the same order, carrying each owner's data.
- start_i with a read in flight and conflict_cnt_o=7 -> the in-flight rvalid still arrives; conflict_cnt_o = 0 on the next cycle.
- rstn low one cycle after a grant -> no rvalid ever asserted; all outputs 0 while in reset.
